fir2p_output_serializer: RTL

- Downstream stage of the two-parallel FIR.
- Each cycle it accepts one even/odd pair of full-precision filter outputs and requantizes both samples: round-half-up, arithmetic right shift, saturate.
- Buffers pairs in a small FIFO and emits them as a single serial stream, even sample first, over a valid/ready handshake.
- Backpressures the FIR pair interface when the buffer is full.

---
 rtl/fir2p_output_serializer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fir2p_output_serializer.sv
// rtl/fir2p_output_serializer.sv - requantize FIR even/odd pairs, buffer them, emit as one serial stream
// Optional build macro: FIR2P_SAT_STATUS_EN adds sat_count / sat_sticky clamp statistics.
module fir2p_output_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_even,
  input  logic [IN_W-1:0]  in_odd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_phase
`ifdef FIR2P_SAT_STATUS_EN
  ,
  output logic [15:0]      sat_count,
  output logic             sat_sticky
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Rounding constant and clamp limits, all in the widened IN_W+1 domain so the
  // rounding add cannot wrap at the positive maximum.
  localparam logic signed [IN_W:0] RND =
    (SHIFT > 0) ? ((IN_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;

  // Round-half-up then arithmetic shift, before clamping.
  function automatic logic signed [IN_W:0] scaled(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] ext;
    ext = {x[IN_W-1], x};
    ext = ext + RND;
    return ext >>> SHIFT;
  endfunction

  function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] s;
    s = scaled(x);
    if (s > MAXV)
      return MAXV[OUT_W-1:0];
    else if (s < MINV)
      return MINV[OUT_W-1:0];
    else
      return s[OUT_W-1:0];
  endfunction

  logic [OUT_W-1:0] mem_even [DEPTH];
  logic [OUT_W-1:0] mem_odd  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  phase_t           state;

  logic [OUT_W-1:0] q_even;
  logic [OUT_W-1:0] q_odd;
  logic             push;
  logic             xfer;
  logic             pop;

  // Handshake decode; readiness looks only at the registered count, so a full
  // buffer never passes a pair through on the same cycle it pops.
  always_comb begin
    q_even    = requant(in_even);
    q_odd     = requant(in_odd);
    in_ready  = rst_n && (count < CW'(DEPTH));
    out_valid = rst_n && (count != '0);
    push      = in_valid && in_ready;
    xfer      = out_valid && out_ready;
    pop       = xfer && (state == ODD);
    out_phase = state;
    if (!out_valid)
      out_data = '0;
    else if (state == ODD)
      out_data = mem_odd[rd_ptr];
    else
      out_data = mem_even[rd_ptr];
  end

  // Pair storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_even[wr_ptr] <= q_even;
      mem_odd[wr_ptr]  <= q_odd;
    end
  end

  // Pointers, occupancy and the even/odd output phase FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= EVEN;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (xfer)
        state <= (state == EVEN) ? ODD : EVEN;
    end
  end

`ifdef FIR2P_SAT_STATUS_EN
  logic        clamp_even;
  logic        clamp_odd;
  logic [16:0] sat_sum;

  // Clamp detection on the accepted pair and the saturating statistics sum.
  always_comb begin
    clamp_even = (scaled(in_even) > MAXV) || (scaled(in_even) < MINV);
    clamp_odd  = (scaled(in_odd) > MAXV) || (scaled(in_odd) < MINV);
    sat_sum    = {1'b0, sat_count} + 17'(clamp_even) + 17'(clamp_odd);
  end

  // Clamp statistics; only rst_n clears them, the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count  <= '0;
      sat_sticky <= 1'b0;
    end else if (push) begin
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      if (clamp_even || clamp_odd)
        sat_sticky <= 1'b1;
    end
  end
`endif

endmodule
